uart_rx_cmd_ctrl: RTL

Command-framing controller that sits directly behind the UART receiver. It consumes the receiver's byte-valid, byte and parity-error outputs. It assembles fixed-format frames (header, opcode, address, data, optional checksum) and presents each validated command on a valid/ready interface to the core's register/configuration bus. Malformed, parity-failed or stalled frames are dropped and counted.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_timeout.sv | 26 ++
 rtl/uart_rx_cmd_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-framing controller: state encoding,
// default frame header and the opcode values carried through to the core.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      S_HUNT  = 3'd0,
      S_OP    = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_CSUM  = 3'd4,
      S_ISSUE = 3'd5
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   // Opcodes are forwarded untouched; the consumer decodes them.
   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_WR  = 8'h01;
   localparam logic [7:0] OP_RD  = 8'h02;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte interval counter: counts while enabled, flags expiry on the cycle
// whose edge would bring the count up to the loaded limit.
module uart_cmd_timeout (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] limit,
   output logic        expire
);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != limit)
         cnt <= cnt + 16'd1;
   end

   // A clear in the same cycle (a byte arriving) always beats expiry.
   assign expire = en && !clr && (cnt + 16'd1 == limit);

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames UART bytes into header/op/addr/data commands for the config bus.
// Optional trailing XOR checksum byte enabled by UART_CMD_CHECKSUM_EN.
module uart_rx_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         DATA_BYTES   = 2,
   parameter logic [7:0] HEADER       = HEADER_DEFAULT,
   parameter int         TIMEOUT_CLKS = 2000
) (
   input  logic                    i_Clock,
   input  logic                    i_Rst_L,
   input  logic                    i_Rx_DV,
   input  logic [7:0]              i_Rx_Byte,
   input  logic                    i_Rx_Error,
   output logic                    o_Cmd_Valid,
   input  logic                    i_Cmd_Ready,
   output logic [7:0]              o_Cmd_Op,
   output logic [7:0]              o_Cmd_Addr,
   output logic [8*DATA_BYTES-1:0] o_Cmd_Data,
   output logic [7:0]              o_Err_Count,
   output logic                    o_Busy
);

   localparam logic [15:0] LIMIT    = 16'(TIMEOUT_CLKS - 1);
   localparam logic [1:0]  LAST_IDX = 2'(DATA_BYTES - 1);

   state_t                         state, state_nxt;
   logic [7:0]                     op_r, addr_r, err_cnt;
   logic [DATA_BYTES-1:0][7:0]     data_r;
   logic [1:0]                     idx;
   logic                           ld_op, ld_addr, ld_data, err_inc;
   logic                           in_frame, expire, byte_ok, byte_bad, abort;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]                     csum;
`endif

   assign byte_ok  = i_Rx_DV && !i_Rx_Error;
   assign byte_bad = i_Rx_DV && i_Rx_Error;
   assign in_frame = (state == S_OP) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CSUM);
   assign abort    = in_frame && (byte_bad || (!i_Rx_DV && expire));

   uart_cmd_timeout u_timeout (
      .clk    (i_Clock),
      .rst_n  (i_Rst_L),
      .clr    (i_Rx_DV || !in_frame),
      .en     (in_frame),
      .limit  (LIMIT),
      .expire (expire)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L)
         state <= S_HUNT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_op     = 1'b0;
      ld_addr   = 1'b0;
      ld_data   = 1'b0;
      err_inc   = 1'b0;
      if (abort) begin
         state_nxt = S_HUNT;
         err_inc   = 1'b1;
      end else begin
         case (state)
            S_HUNT:
               if (byte_ok && i_Rx_Byte == HEADER) state_nxt = S_OP;
            S_OP:
               if (byte_ok) begin
                  ld_op     = 1'b1;
                  state_nxt = S_ADDR;
               end
            S_ADDR:
               if (byte_ok) begin
                  ld_addr   = 1'b1;
                  state_nxt = S_DATA;
               end
            S_DATA:
               if (byte_ok) begin
                  ld_data = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                  if (idx == LAST_IDX) state_nxt = S_CSUM;
`else
                  if (idx == LAST_IDX) state_nxt = S_ISSUE;
`endif
               end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM:
               if (byte_ok) begin
                  if (i_Rx_Byte == csum) begin
                     state_nxt = S_ISSUE;
                  end else begin
                     state_nxt = S_HUNT;
                     err_inc   = 1'b1;
                  end
               end
`endif
            S_ISSUE: begin
               // Bytes landing while a command waits are overruns.
               if (i_Rx_DV) err_inc = 1'b1;
               if (i_Cmd_Ready) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         op_r    <= '0;
         addr_r  <= '0;
         data_r  <= '0;
         idx     <= '0;
         err_cnt <= '0;
      end else begin
         if (ld_op) op_r <= i_Rx_Byte;
         if (ld_addr) begin
            addr_r <= i_Rx_Byte;
            idx    <= '0;
         end
         if (ld_data) idx <= idx + 2'd1;
         for (int i = 0; i < DATA_BYTES; i++)
            if (ld_data && idx == 2'(i)) data_r[i] <= i_Rx_Byte;
         if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

`ifdef UART_CMD_CHECKSUM_EN
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L)
         csum <= '0;
      else if (ld_op)
         csum <= i_Rx_Byte;
      else if (ld_addr || ld_data)
         csum <= csum ^ i_Rx_Byte;
   end
`endif

   assign o_Cmd_Valid = (state == S_ISSUE);
   assign o_Busy      = (state != S_HUNT);
   assign o_Cmd_Op    = op_r;
   assign o_Cmd_Addr  = addr_r;
   assign o_Cmd_Data  = data_r;
   assign o_Err_Count = err_cnt;

endmodule
